adc_pattern_gen: RTL

Parametrised multi-channel ADC stimulus model for AXI4-Stream master benches. It generates deterministic per-channel sample streams in one of four modes: ramp, triangle, pseudo-random or constant. Samples are produced at a programmable sub-rate of the ADC clock, with a one-cycle valid strobe and a running sample count. It replaces the free-running 14-bit ramp source and feeds the AXIS master under test.

---
 rtl/adc_pattern_pkg.sv | 24 ++
 rtl/adc_rate_div.sv | 25 ++
 rtl/adc_pattern_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/adc_pattern_pkg.sv
// Shared encodings and the LFSR step function for the ADC pattern generator.
package adc_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_TRI   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Galois shift-right: feedback taps applied when the bit shifted out is set.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/adc_rate_div.sv
// Sample-rate divider: one-cycle tick every clk_div+1 enabled cycles.
module adc_rate_div #(
  parameter int DIV_W = 8
) (
  input  logic             adc_clk,
  input  logic             adc_resetn,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  assign tick = enable && (div_cnt == clk_div);

  always_ff @(posedge adc_clk or negedge adc_resetn) begin
    if (!adc_resetn)
      div_cnt <= '0;
    else if (!enable || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/adc_pattern_gen.sv
// Multi-channel ADC stimulus source: ramp / triangle / LFSR / constant patterns.
// Define ADC_PATTERN_LFSR_EN to build the LFSR mode; otherwise mode 2 acts as ramp.
module adc_pattern_gen
  import adc_pattern_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int NUM_CH    = 1,
  parameter int CH_OFFSET = 0,
  parameter int DIV_W     = 8
) (
  input  logic                     adc_clk,
  input  logic                     adc_resetn,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [DIV_W-1:0]         clk_div,
  input  logic [DATA_W-1:0]        step,
  input  logic [DATA_W-1:0]        limit,
  output logic [NUM_CH*DATA_W-1:0] adc_data,
  output logic                     adc_valid,
  output logic [31:0]              sample_cnt
);

  logic tick;

  adc_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .adc_clk    (adc_clk),
    .adc_resetn (adc_resetn),
    .enable     (enable),
    .clk_div    (clk_div),
    .tick       (tick)
  );

  logic [DATA_W-1:0]        base_p0, base_next;
  dir_e                     dir_p0, dir_next, dir_eff;
  mode_e                    mode_p0, mode_s;
  logic [DATA_W:0]          sum_w;
  logic [NUM_CH*DATA_W-1:0] data_next;
`ifdef ADC_PATTERN_LFSR_EN
  logic [15:0]              lfsr_p0, lfsr_nxt;
`endif

  // Next-sample computation, decided and registered on the tick edge
  always_comb begin
    mode_s    = mode_e'(mode);
    dir_eff   = (mode_s == mode_p0) ? dir_p0 : DIR_UP;
    sum_w     = {1'b0, base_p0} + {1'b0, step};
    base_next = sum_w[DATA_W-1:0];
    dir_next  = DIR_UP;
`ifdef ADC_PATTERN_LFSR_EN
    lfsr_nxt  = lfsr_p0;
`endif
    case (mode_s)
      MODE_TRI: begin
        if (dir_eff == DIR_UP) begin
          if (sum_w >= {1'b0, limit}) begin
            base_next = limit;
            dir_next  = DIR_DOWN;
          end else begin
            dir_next  = DIR_UP;
          end
        end else if (base_p0 <= step) begin
          base_next = '0;
          dir_next  = DIR_UP;
        end else begin
          base_next = base_p0 - step;
          dir_next  = DIR_DOWN;
        end
      end
`ifdef ADC_PATTERN_LFSR_EN
      MODE_LFSR: begin
        lfsr_nxt  = lfsr_next(lfsr_p0);
        base_next = lfsr_nxt[DATA_W-1:0];
      end
`endif
      MODE_CONST: base_next = limit;
      default:    base_next = sum_w[DATA_W-1:0];
    endcase

    data_next = '0;
    for (int k = 0; k < NUM_CH; k++)
      data_next[k*DATA_W +: DATA_W] = base_next + DATA_W'(k * CH_OFFSET);
  end

  always_ff @(posedge adc_clk or negedge adc_resetn) begin
    if (!adc_resetn) begin
      base_p0    <= '0;
      dir_p0     <= DIR_UP;
      mode_p0    <= MODE_RAMP;
      adc_data   <= '0;
      adc_valid  <= 1'b0;
      sample_cnt <= '0;
    end else begin
      adc_valid <= tick;
      if (tick) begin
        base_p0    <= base_next;
        dir_p0     <= dir_next;
        mode_p0    <= mode_s;
        adc_data   <= data_next;
        sample_cnt <= sample_cnt + 32'd1;
      end
    end
  end

`ifdef ADC_PATTERN_LFSR_EN
  always_ff @(posedge adc_clk or negedge adc_resetn) begin
    if (!adc_resetn)
      lfsr_p0 <= LFSR_SEED;
    else if (tick)
      lfsr_p0 <= lfsr_nxt;
  end
`endif

endmodule
